// File: rtl/a_feed_if.sv
// Row-feed bus between the tile source, the A-feed controller and the A-FIFO bank.
// The master modport is the row producer and FIFO observer; the slave modport is the controller.
interface a_feed_if #(
  parameter int DIM  = 8,
  parameter int BITS = 64
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DIM-1:0][BITS-1:0] in_data;
  logic [DIM-1:0]           wr_en;
  logic [DIM-1:0][BITS-1:0] wr_data;
  logic                     fifo_en;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_data, fifo_en
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_data, fifo_en
  );
endinterface

// File: rtl/a_feed_ctrl.sv
// Loads one DIM-row tile into the A-FIFO bank, one row per accepted handshake,
// then streams the FIFOs for DEPTH+DIM-1 cycles and pulses done.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | accepting rows, in_ready high
//   FLUSH  | last row's write strobe in flight
//   STREAM | fifo_en high, stream_cnt counting down
//   DONE   | one-cycle done pulse
module a_feed_ctrl #(
  parameter int DIM   = 8,
  parameter int BITS  = 64,
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  output logic     busy,
  output logic     done,
  a_feed_if.slave  bus
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int SW = $clog2(DEPTH + DIM);
  localparam logic [RW-1:0] LAST_ROW    = RW'(DIM - 1);
  localparam logic [SW-1:0] STREAM_LAST = SW'(DEPTH + DIM - 2);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, STREAM, DONE} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row_cnt;
  logic [SW-1:0] stream_cnt;
  logic          accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are pure state decode so nothing combinational leaks from in_valid or start.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.fifo_en  = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        if (accept && row_cnt == LAST_ROW) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = STREAM;
      STREAM: begin
        bus.fifo_en = 1'b1;
        if (stream_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt     <= '0;
      stream_cnt  <= '0;
      bus.wr_en   <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= '0;
      if (state == IDLE && start) row_cnt <= '0;
      if (accept) begin
        bus.wr_en   <= DIM'(1) << row_cnt;
        bus.wr_data <= bus.in_data;
        // Saturate on the last row so the counter never wraps inside a tile.
        if (row_cnt != LAST_ROW) row_cnt <= row_cnt + RW'(1);
      end
      if (state == FLUSH)
        stream_cnt <= STREAM_LAST;
      else if (state == STREAM && stream_cnt != '0)
        stream_cnt <= stream_cnt - SW'(1);
    end
  end
endmodule

// File: tb/tb_a_feed_ctrl.sv
// Randomized bench for a_feed_ctrl with a bank of behavioural A-FIFOs on the outputs.
module tb_a_feed_ctrl;
  localparam int DIM   = 8;
  localparam int BITS  = 64;
  localparam int DEPTH = 8;
  localparam int W     = DIM * BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  a_feed_if #(.DIM(DIM), .BITS(BITS)) bus ();

  a_feed_ctrl #(.DIM(DIM), .BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [DIM-1:0][BITS-1:0] mat [DIM];
  logic [BITS-1:0] fq   [DIM][$];
  logic [BITS-1:0] qobs [DIM][$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] junk();
    logic [W-1:0] j;
    for (int i = 0; i < W / 32; i++) j[i*32 +: 32] = $urandom;
    return j;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_cyc(input string ph, input logic rdy, input logic bsy,
                            input logic [DIM-1:0] we, input logic fen, input logic dn);
    chk({ph, ".in_ready"}, W'(bus.in_ready), W'(rdy));
    chk({ph, ".busy"},     W'(busy),         W'(bsy));
    chk({ph, ".wr_en"},    W'(bus.wr_en),    W'(we));
    chk({ph, ".fifo_en"},  W'(bus.fifo_en),  W'(fen));
    chk({ph, ".done"},     W'(done),         W'(dn));
  endtask

  // Downstream A-FIFOs: a write loads a whole row, each shift pops one element to q.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(bus.fifo_en && |bus.wr_en)) else chk("overlap", W'(1), W'(0));
      for (int r = 0; r < DIM; r++) begin
        if (bus.fifo_en && fq[r].size() > 0) qobs[r].push_back(fq[r].pop_front());
        if (bus.wr_en[r])
          for (int c = 0; c < DIM; c++) fq[r].push_back(bus.wr_data[c]);
      end
    end
  end

  // mode 0: back-to-back rows, 1: valid pattern 1,0,0, 2: random valid and data
  task automatic run_tile(input int mode, input int abort_k);
    logic [DIM-1:0] pend;
    logic [W-1:0]   last;
    logic [DIM-1:0][BITS-1:0] got;
    bit have, v;
    int r, n;
    for (int i = 0; i < DIM; i++) begin
      fq[i].delete();
      qobs[i].delete();
      for (int c = 0; c < DIM; c++)
        mat[i][c] = (mode < 2) ? BITS'(i * 16 + c) : BITS'({$urandom, $urandom});
    end
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = junk();
    step();
    start = 1'b0;
    pend = '0;
    last = '0;
    have = 1'b0;
    r = 0;
    n = 0;
    while (r < DIM) begin
      expect_cyc("load", 1'b1, 1'b1, pend, 1'b0, 1'b0);
      if (have) chk("load.wr_data", bus.wr_data, last);
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 3 == 0);
        default: v = (n > 40) || ($urandom_range(0, 1) == 1);
      endcase
      n++;
      bus.in_valid = v;
      bus.in_data = v ? mat[r] : junk();
      start = ($urandom_range(0, 1) == 1);
      step();
      if (v) begin
        pend = DIM'(1) << r;
        last = mat[r];
        have = 1'b1;
        r++;
      end else begin
        pend = '0;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data = junk();
    expect_cyc("flush", 1'b0, 1'b1, pend, 1'b0, 1'b0);
    chk("flush.wr_data", bus.wr_data, last);
    step();
    for (int k = 0; k < DEPTH + DIM - 1; k++) begin
      expect_cyc("stream", 1'b0, 1'b1, '0, 1'b1, 1'b0);
      chk("stream.wr_data", bus.wr_data, last);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        expect_cyc("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("rst.wr_data", bus.wr_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          step();
          expect_cyc("post_rst", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
        return;
      end
      start = ($urandom_range(0, 1) == 1);
      bus.in_valid = ($urandom_range(0, 1) == 1);
      step();
    end
    expect_cyc("done", 1'b0, 1'b1, '0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    expect_cyc("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    start = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      chk("e2e.count", W'(qobs[i].size()), W'(DIM));
      got = '0;
      for (int c = 0; c < DIM && c < qobs[i].size(); c++) got[c] = qobs[i][c];
      chk("e2e.row", got, mat[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    #12;
    expect_cyc("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("reset.wr_data", bus.wr_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = junk();
      step();
      expect_cyc("idle_valid", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    run_tile(0, -1);
    run_tile(1, -1);
    run_tile(2, -1);
    run_tile(2, 5);
    run_tile(0, -1);
    for (int t = 0; t < 3; t++) run_tile(2, -1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/a_feed_ctrl.md
A_FEED_CTRL -- requirements
Module: a_feed_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8, meaning the array dimension: rows per tile, elements per row, and number of A-FIFOs fed.
REQ-002 SHALL have parameter BITS, default 64, meaning the element width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning the depth of each downstream A-FIFO.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin a tile; sampled only in IDLE.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a valid row.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a row this cycle.
REQ-009 SHALL have port in_data, input, DIM x BITS: one row, element 0 first.
REQ-010 SHALL have port wr_en, output, DIM bits: one-hot write strobe, bit r drives WrEn of A-FIFO r.
REQ-011 SHALL have port wr_data, output, DIM x BITS: row data broadcast to the d input of every A-FIFO.
REQ-012 SHALL have port fifo_en, output, 1 bit: shift enable shared by all A-FIFOs.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at tile completion.

Function
REQ-015 SHALL implement states IDLE, LOAD, FLUSH, STREAM, DONE.
REQ-016 SHALL go IDLE->LOAD on the edge where start=1 and clear row counter row_cnt to 0.
REQ-017 SHALL hold in_ready=1 only in LOAD and 0 in all other states.
REQ-018 SHALL accept a row on any edge where in_valid and in_ready are both 1; in_valid low stalls LOAD with no timeout.
REQ-019 SHALL, on acceptance, register wr_data<=in_data and drive wr_en=1<<row_cnt for exactly the following cycle, then increment row_cnt.
REQ-020 SHALL drive wr_en to all-zero in every cycle that does not follow an acceptance; at most one bit is ever high.
REQ-021 SHALL hold wr_data at its last value when no row is accepted.
REQ-022 SHALL go LOAD->FLUSH on acceptance of row DIM-1; FLUSH lasts 1 cycle, during which wr_en[DIM-1]=1.
REQ-023 SHALL go FLUSH->STREAM unconditionally, so fifo_en is never high in the same cycle as any wr_en bit.
REQ-024 SHALL assert fifo_en=1 in every STREAM cycle; STREAM lasts exactly DEPTH+DIM-1 cycles, counted by stream_cnt of width $clog2(DEPTH+DIM).
REQ-025 SHALL go STREAM->DONE after the final stream cycle; DONE lasts 1 cycle with done=1 and fifo_en=0, then goes DONE->IDLE.
REQ-026 SHALL ignore start in every state except IDLE; start held high in DONE causes no restart until IDLE is reached.
REQ-027 SHALL size row_cnt at $clog2(DIM) bits (minimum 1); row_cnt never wraps within a tile.
REQ-028 SHALL drive fifo_en, wr_en, done and in_ready directly from registers or state decode, with no combinational path from in_valid or start.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force state=IDLE, row_cnt=0, stream_cnt=0, wr_en=0, wr_data=0, fifo_en=0, done=0, busy=0, in_ready=0.
REQ-030 SHALL, on reset asserted mid-LOAD or mid-STREAM, abandon the tile; after release the block waits in IDLE for a new start, with no partial rows or enables issued.

Verification
REQ-031 SHALL cover nominal tile (DIM=8, DEPTH=8): start, then 8 back-to-back valid rows -> wr_en goes 0x01..0x80 on consecutive cycles, 1 FLUSH cycle, fifo_en high 15 cycles, done pulse 1 cycle, busy low after.
REQ-032 SHALL cover stalled input: in_valid toggled 1,0,0,1,... -> wr_en bits appear only after accepted cycles, in order, with no duplicate or skipped bit.
REQ-033 SHALL cover data integrity: row r elements = r*16+c -> wr_data during wr_en[r] equals exactly that row.
REQ-034 SHALL cover spurious control: start pulsed during LOAD and STREAM, and in_valid high in IDLE -> no state change, in_ready stays 0 outside LOAD.
REQ-035 SHALL cover reset in STREAM: rst_n low at stream cycle 5 -> all outputs 0 immediately; a new start after release runs a complete, correct tile.
REQ-036 SHALL cover end-to-end with DIM A-FIFOs attached: known 8x8 matrix loaded -> FIFO r's q sequence matches row r, and fifo_en is never coincident with wr_en, checked by assertion.
